// File: rtl/projector_pipe.sv
// projector_pipe: sequential perspective projector.
// Accepts one signed vertex per valid/ready handshake, divides x*FOCAL and
// y*FOCAL by (z+Z_OFFSET) with two iterative restoring dividers, adds the
// screen centre and clamps to the screen.
// Optional feature macro: PROJ_NEAR_CULL_EN (near-plane vertices bypass the
// dividers and are flagged on out_clip).
module projector_pipe #(
    parameter int COORD_W      = 10,
    parameter int SCR_W        = 10,
    parameter int DIV_W        = 24,
    parameter int FOCAL_LENGTH = 800,
    parameter int Z_OFFSET     = 400,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] in_x,
    input  logic signed [COORD_W-1:0] in_y,
    input  logic signed [COORD_W-1:0] in_z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [SCR_W-1:0]   out_x,
    output logic        [SCR_W-1:0]   out_y,
    output logic signed [COORD_W-1:0] out_z,
    output logic                      out_clip
);

    localparam int NUM_W      = DIV_W + 1;
    localparam int EXT_W      = DIV_W + 2;
    localparam int CNT_W      = $clog2(DIV_W + 1);
    localparam int FOCAL_MAG  = (FOCAL_LENGTH < 0) ? -FOCAL_LENGTH : FOCAL_LENGTH;
    localparam int FOCAL_BITS = $clog2(FOCAL_MAG + 1);

    localparam logic signed [NUM_W-1:0] FOCAL_S = NUM_W'(FOCAL_LENGTH);
    localparam logic signed [EXT_W-1:0] ZOFF_S  = EXT_W'(Z_OFFSET);
    localparam logic signed [EXT_W-1:0] HALF_X  = EXT_W'(SCREEN_W / 2);
    localparam logic signed [EXT_W-1:0] HALF_Y  = EXT_W'(SCREEN_H / 2);
    localparam logic signed [EXT_W-1:0] MAX_X   = EXT_W'(SCREEN_W - 1);
    localparam logic signed [EXT_W-1:0] MAX_Y   = EXT_W'(SCREEN_H - 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DIV_W - 1);

    // Numerator magnitudes must fit the divider width.
    if (DIV_W < COORD_W + FOCAL_BITS) begin : g_div_w_check
        $error("projector_pipe: DIV_W too small for COORD_W and FOCAL_LENGTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [COORD_W-1:0] r_x, r_y, r_z;
    logic        [DIV_W-1:0]   r_dvs;
    logic        [DIV_W-1:0]   r_rem_x, r_rem_y;
    logic        [DIV_W-1:0]   r_q_x, r_q_y;
    logic                      r_neg_x, r_neg_y;
    logic        [CNT_W-1:0]   r_cnt;
    logic                      r_out_valid;
    logic        [SCR_W-1:0]   r_out_x, r_out_y;
    logic signed [COORD_W-1:0] r_out_z;

    logic signed [NUM_W-1:0] w_x_ext, w_y_ext, w_num_x, w_num_y;
    logic signed [EXT_W-1:0] w_z_ext, w_z_dist;
    logic                    w_near;
    logic        [DIV_W-1:0] w_mag_x, w_mag_y, w_dvs_load;
    logic        [DIV_W:0]   w_sh_x, w_sh_y, w_tr_x, w_tr_y;
    logic signed [EXT_W-1:0] w_qe_x, w_qe_y, w_sum_x, w_sum_y;
    logic        [SCR_W-1:0] w_res_x, w_res_y;

    // LOAD-stage arithmetic: sign extension, z distance and numerators.
    assign w_x_ext  = {{(NUM_W-COORD_W){r_x[COORD_W-1]}}, r_x};
    assign w_y_ext  = {{(NUM_W-COORD_W){r_y[COORD_W-1]}}, r_y};
    assign w_z_ext  = {{(EXT_W-COORD_W){r_z[COORD_W-1]}}, r_z};
    assign w_z_dist = w_z_ext + ZOFF_S;
    assign w_near   = w_z_dist[EXT_W-1] || (w_z_dist == '0);
    assign w_num_x  = w_x_ext * FOCAL_S;
    assign w_num_y  = w_y_ext * FOCAL_S;
    assign w_mag_x  = w_num_x[NUM_W-1] ? (~w_num_x[DIV_W-1:0] + 1'b1) : w_num_x[DIV_W-1:0];
    assign w_mag_y  = w_num_y[NUM_W-1] ? (~w_num_y[DIV_W-1:0] + 1'b1) : w_num_y[DIV_W-1:0];
    // A non-positive distance divides by 1 so the uncull path saturates via the clamp.
    assign w_dvs_load = w_near ? DIV_W'(1) : w_z_dist[DIV_W-1:0];

    // Restoring divider step; remainder stays below the divisor so the
    // trial difference MSB is a clean borrow flag.
    assign w_sh_x = {r_rem_x, r_q_x[DIV_W-1]};
    assign w_sh_y = {r_rem_y, r_q_y[DIV_W-1]};
    assign w_tr_x = w_sh_x - {1'b0, r_dvs};
    assign w_tr_y = w_sh_y - {1'b0, r_dvs};

    // Result stage: signed quotient, centre offset, clamp.
    assign w_qe_x  = {2'b00, r_q_x};
    assign w_qe_y  = {2'b00, r_q_y};
    assign w_sum_x = (r_neg_x ? -w_qe_x : w_qe_x) + HALF_X;
    assign w_sum_y = (r_neg_y ? -w_qe_y : w_qe_y) + HALF_Y;

    // Clamp both coordinates into the visible screen.
    always_comb begin
        w_res_x = w_sum_x[SCR_W-1:0];
        w_res_y = w_sum_y[SCR_W-1:0];
        if (w_sum_x[EXT_W-1]) begin
            w_res_x = '0;
        end else if (w_sum_x > MAX_X) begin
            w_res_x = MAX_X[SCR_W-1:0];
        end
        if (w_sum_y[EXT_W-1]) begin
            w_res_y = '0;
        end else if (w_sum_y > MAX_Y) begin
            w_res_y = MAX_Y[SCR_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = S_LOAD;
`ifdef PROJ_NEAR_CULL_EN
            S_LOAD: w_next = w_near ? S_DONE : S_DIV;
`else
            S_LOAD: w_next = S_DIV;
`endif
            S_DIV:  if (r_cnt == CNT_LAST) w_next = S_DONE;
            S_DONE: if (r_out_valid && out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign in_ready = (r_state == S_IDLE);

    // Vertex capture and divider datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_dvs   <= '0;
            r_rem_x <= '0;
            r_rem_y <= '0;
            r_q_x   <= '0;
            r_q_y   <= '0;
            r_neg_x <= 1'b0;
            r_neg_y <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x <= in_x;
                        r_y <= in_y;
                        r_z <= in_z;
                    end
                end
                S_LOAD: begin
                    r_dvs   <= w_dvs_load;
                    r_q_x   <= w_mag_x;
                    r_q_y   <= w_mag_y;
                    r_neg_x <= w_num_x[NUM_W-1];
                    r_neg_y <= w_num_y[NUM_W-1];
                    r_rem_x <= '0;
                    r_rem_y <= '0;
                    r_cnt   <= '0;
                end
                S_DIV: begin
                    r_rem_x <= w_tr_x[DIV_W] ? w_sh_x[DIV_W-1:0] : w_tr_x[DIV_W-1:0];
                    r_rem_y <= w_tr_y[DIV_W] ? w_sh_y[DIV_W-1:0] : w_tr_y[DIV_W-1:0];
                    r_q_x   <= {r_q_x[DIV_W-2:0], ~w_tr_x[DIV_W]};
                    r_q_y   <= {r_q_y[DIV_W-2:0], ~w_tr_y[DIV_W]};
                    r_cnt   <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PROJ_NEAR_CULL_EN
    logic r_clip;
    logic r_out_clip;

    // Near-plane flag latched in LOAD, published with the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clip     <= 1'b0;
            r_out_clip <= 1'b0;
        end else begin
            if (r_state == S_LOAD) r_clip <= w_near;
            if (r_state == S_DONE && !r_out_valid) r_out_clip <= r_clip;
        end
    end
    assign out_clip = r_out_clip;
`else
    logic r_clip;
    assign r_clip   = 1'b0;
    assign out_clip = 1'b0;
`endif

    // Output registers: the first DONE cycle loads the result, then it is
    // held until the downstream handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_z     <= '0;
        end else if (r_state == S_DONE) begin
            if (!r_out_valid) begin
                r_out_valid <= 1'b1;
                r_out_z     <= r_z;
                r_out_x     <= r_clip ? '0 : w_res_x;
                r_out_y     <= r_clip ? '0 : w_res_y;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_z     = r_out_z;

endmodule
